// File: rtl/sr_cmd_gen.sv
// ---------------------------------------------------------------------------
// sr_cmd_gen
//
// Command front end for an SR flip-flop. Two asynchronous request lines are
// each synchronized (2 flops), debounced, and turned into a single-cycle
// command pulse on their debounced rising edge. A small FSM arbitrates the
// two channels so that s and r are never high on the same cycle, and applies
// an optional lockout window after every issued command.
//
// Parameters
//   DB_CYCLES  consecutive stable synchronized cycles before a debounced
//              level may change (>= 1)
//   HOLDOFF    lockout cycles after any issued command (0 = no lockout)
//
// Ports
//   clk       in   single clock, all state updates on posedge
//   rst       in   synchronous active-low reset
//   set_req   in   asynchronous set request, active high
//   clr_req   in   asynchronous clear request, active high
//   s         out  registered one-cycle set pulse
//   r         out  registered one-cycle reset pulse
//   busy      out  high while the lockout window is active
//   conflict  out  one-cycle pulse when set and clear edges coincide
//   dropped   out  one-cycle pulse when an edge is discarded during lockout
// ---------------------------------------------------------------------------
module sr_cmd_gen #(
    parameter int DB_CYCLES = 4,
    parameter int HOLDOFF   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict,
    output logic dropped
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_INIT = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Channel index 0 = set, 1 = clear.
    logic [1:0]    req;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db;
    logic [CW-1:0] cnt [2];
    logic [1:0]    ev;

    state_t        state;
    logic [HW-1:0] hcnt;

    logic set_ev;
    logic clr_ev;

    assign req = {clr_req, set_req};

    // A rising event is the posedge on which db flips 0 -> 1: db is low,
    // sync2 disagrees (so it is high), and the stability count is complete.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            ev[c] = ~db[c] & sync2[c] & (cnt[c] == CNT_LAST);
        end
    end

    assign set_ev = ev[0];
    assign clr_ev = ev[1];

    // Synchronizers and debouncers for both channels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            for (int c = 0; c < 2; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            sync1 <= req;
            sync2 <= sync1;
            for (int c = 0; c < 2; c++) begin
                if (sync2[c] == db[c]) begin
                    // Any return to the current level restarts the count,
                    // so short glitches never reach db.
                    cnt[c] <= '0;
                end else if (cnt[c] == CNT_LAST) begin
                    db[c]  <= sync2[c];
                    cnt[c] <= '0;
                end else begin
                    cnt[c] <= cnt[c] + CW'(1);
                end
            end
        end
    end

    // Arbitration / lockout FSM with registered outputs.
    // busy is registered from the current state, so it trails the state by
    // one cycle: it covers the cycles after posedges t+1 .. t+HOLDOFF for a
    // command issued at posedge t.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            hcnt     <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
            dropped  <= 1'b0;
            busy     <= (state == HOLD);
            case (state)
                IDLE: begin
                    if (set_ev || clr_ev) begin
                        // Clear wins on a tie: reset is the safe state.
                        if (clr_ev) begin
                            r        <= 1'b1;
                            conflict <= set_ev;
                        end else begin
                            s <= 1'b1;
                        end
                        if (HOLDOFF > 0) begin
                            state <= HOLD;
                            hcnt  <= HCNT_INIT;
                        end
                    end
                end
                HOLD: begin
                    // An event on the expiry posedge is still dropped.
                    if (set_ev || clr_ev) begin
                        dropped <= 1'b1;
                    end
                    if (hcnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hcnt <= hcnt - HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// ---------------------------------------------------------------------------
// tb_sr_cmd_gen
//
// Two DUT instances: dut0 with default parameters (DB_CYCLES=4, HOLDOFF=8)
// and dut1 with HOLDOFF=0. Inputs change only just after a negedge; the
// reference model advances on posedge and outputs are compared on negedge.
//
// Model: a channel's debounced level flips when the last DB_CYCLES
// synchronized samples (the request delayed by two posedges) all disagree
// with it. A command at posedge t locks out posedges t+1 .. t+HOLDOFF, and
// busy is high after exactly those posedges.
// ---------------------------------------------------------------------------
module tb_sr_cmd_gen;

    localparam int TB_DB  = 4;
    localparam int TB_HO0 = 8;
    localparam int TB_HO1 = 0;

    // Clock / reset
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic set0, clr0, s0, r0, busy0, conflict0, dropped0;
    logic set1, clr1, s1, r1, busy1, conflict1, dropped1;

    sr_cmd_gen #(.DB_CYCLES(TB_DB), .HOLDOFF(TB_HO0)) dut0 (
        .clk(clk), .rst(rst), .set_req(set0), .clr_req(clr0),
        .s(s0), .r(r0), .busy(busy0), .conflict(conflict0), .dropped(dropped0)
    );

    sr_cmd_gen #(.DB_CYCLES(TB_DB), .HOLDOFF(TB_HO1)) dut1 (
        .clk(clk), .rst(rst), .set_req(set1), .clr_req(clr1),
        .s(s1), .r(r1), .busy(busy1), .conflict(conflict1), .dropped(dropped1)
    );

    // Scoreboard counters
    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    int s_cnt0     = 0;
    int r_cnt0     = 0;
    int drop_cnt0  = 0;
    int busy_cnt1  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model
    logic [31:0] hist  [2][2];
    bit          mdb   [2][2];
    bit          req_m [2][2];
    bit          ev_m  [2];
    bit          all_opp;
    bit          locked;
    int          last_cmd [2];
    int          hold_v;
    int          cyc = 0;
    bit e_s [2], e_r [2], e_busy [2], e_conf [2], e_drop [2];

    always @(posedge clk) begin
        cyc = cyc + 1;
        req_m[0][0] = set0; req_m[0][1] = clr0;
        req_m[1][0] = set1; req_m[1][1] = clr1;
        for (int i = 0; i < 2; i++) begin
            hold_v = (i == 0) ? TB_HO0 : TB_HO1;
            e_s[i] = 0; e_r[i] = 0; e_busy[i] = 0; e_conf[i] = 0; e_drop[i] = 0;
            if (!rst) begin
                for (int c = 0; c < 2; c++) begin
                    hist[i][c] = '0;
                    mdb[i][c]  = 0;
                end
                last_cmd[i] = -100000;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    all_opp = 1;
                    for (int k = 1; k <= TB_DB; k++) begin
                        if (hist[i][c][k] == mdb[i][c]) all_opp = 0;
                    end
                    ev_m[c] = 0;
                    if (all_opp) begin
                        mdb[i][c] = ~mdb[i][c];
                        ev_m[c]   = mdb[i][c];
                    end
                    hist[i][c] = {hist[i][c][30:0], req_m[i][c]};
                end
                locked = (hold_v > 0) && (cyc - last_cmd[i] >= 1) &&
                         (cyc - last_cmd[i] <= hold_v);
                e_busy[i] = locked;
                if (ev_m[0] || ev_m[1]) begin
                    if (locked) begin
                        e_drop[i] = 1;
                    end else begin
                        if (ev_m[1]) begin
                            e_r[i]    = 1;
                            e_conf[i] = ev_m[0];
                        end else begin
                            e_s[i] = 1;
                        end
                        last_cmd[i] = cyc;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, both instances.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("s0", s0, e_s[0]);
            chk("r0", r0, e_r[0]);
            chk("busy0", busy0, e_busy[0]);
            chk("conflict0", conflict0, e_conf[0]);
            chk("dropped0", dropped0, e_drop[0]);
            chk("s_and_r0", s0 & r0, 0);
            chk("s1", s1, e_s[1]);
            chk("r1", r1, e_r[1]);
            chk("busy1", busy1, e_busy[1]);
            chk("conflict1", conflict1, e_conf[1]);
            chk("dropped1", dropped1, e_drop[1]);
            chk("s_and_r1", s1 & r1, 0);
            if (s0)       s_cnt0++;
            if (r0)       r_cnt0++;
            if (dropped0) drop_cnt0++;
            if (busy1)    busy_cnt1++;
        end
    end

    task automatic holdoff_edge(input int lag, input bit exp_r);
        set0 = 1;
        step(lag);
        clr0 = 1;
        step(6);
        chk("edge_r", r0, exp_r);
        chk("edge_dropped", dropped0, !exp_r);
        set0 = 0;
        clr0 = 0;
        step(25);
    endtask

    int s_base, r_base, d_base;

    initial begin
        rst = 0; set0 = 0; clr0 = 0; set1 = 0; clr1 = 0;
        step(3);
        chk_en = 1;
        chk("rst_s", s0, 0);
        chk("rst_r", r0, 0);
        chk("rst_busy", busy0, 0);
        rst = 1;
        step(2);

        // Set request held: s after the 5th posedge, then 8 busy cycles.
        set0 = 1;
        step(5);
        chk("lat_s_early", s0, 0);
        step(1);
        chk("lat_s", s0, 1);
        chk("lat_r", r0, 0);
        chk("lat_busy_first", busy0, 0);
        step(1);
        chk("lat_s_width", s0, 0);
        chk("lat_busy_on", busy0, 1);
        step(7);
        chk("lat_busy_last", busy0, 1);
        step(1);
        chk("lat_busy_off", busy0, 0);
        set0 = 0;
        step(10);

        // Glitch of 3 cycles never reaches the debounced level.
        s_base = s_cnt0; r_base = r_cnt0; d_base = drop_cnt0;
        set0 = 1;
        step(3);
        set0 = 0;
        step(10);
        chk("glitch_s", s_cnt0 - s_base, 0);
        chk("glitch_r", r_cnt0 - r_base, 0);
        chk("glitch_drop", drop_cnt0 - d_base, 0);

        // Simultaneous edges: clear wins and conflict pulses.
        set0 = 1; clr0 = 1;
        step(5);
        chk("conf_r_early", r0, 0);
        step(1);
        chk("conf_r", r0, 1);
        chk("conf_flag", conflict0, 1);
        chk("conf_s", s0, 0);
        step(1);
        chk("conf_r_width", r0, 0);
        chk("conf_flag_width", conflict0, 0);
        set0 = 0; clr0 = 0;
        step(20);

        // Clear edge inside lockout is dropped; a later one is accepted.
        set0 = 1;
        step(4);
        clr0 = 1;
        step(2);
        chk("lock_s", s0, 1);
        step(4);
        chk("lock_dropped", dropped0, 1);
        chk("lock_r", r0, 0);
        chk("lock_busy", busy0, 1);
        clr0 = 0; set0 = 0;
        step(8);
        chk("lock_busy_off", busy0, 0);
        clr0 = 1;
        step(5);
        chk("late_r_early", r0, 0);
        step(1);
        chk("late_r", r0, 1);
        chk("late_dropped", dropped0, 0);
        clr0 = 0;
        step(20);

        // Lockout boundary: edge at t+8 dropped, at t+9 accepted.
        holdoff_edge(8, 0);
        holdoff_edge(9, 1);

        // Reset mid-debounce: count is lost, r after 6 posedges.
        clr0 = 1;
        step(4);
        rst = 0;
        step(2);
        chk("mid_rst_r", r0, 0);
        chk("mid_rst_busy", busy0, 0);
        rst = 1;
        step(5);
        chk("post_rst_r_early", r0, 0);
        step(1);
        chk("post_rst_r", r0, 1);
        clr0 = 0;
        step(20);

        // HOLDOFF = 0: back-to-back set then clear are both issued.
        set1 = 1;
        step(1);
        clr1 = 1;
        step(5);
        chk("h0_s", s1, 1);
        chk("h0_r_a", r1, 0);
        step(1);
        chk("h0_s_off", s1, 0);
        chk("h0_r", r1, 1);
        step(1);
        chk("h0_r_off", r1, 0);
        set1 = 0; clr1 = 0;
        step(15);
        chk("h0_busy_never", busy_cnt1, 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Command front end that sits directly upstream of the SR flip-flop and drives its `s`/`r` inputs. It synchronizes two asynchronous request lines (set and clear buttons or external strobes), debounces each, converts each debounced rising edge into a single-cycle command pulse, and guarantees `s` and `r` are never high together. The flip-flop's invalid 1/1 input combination therefore cannot occur downstream.

## Interface
- `DB_CYCLES`, default 4: consecutive stable cycles required before a debounced level changes; legal range ≥ 1.
- `HOLDOFF`, default 8: lockout cycles after any issued command; 0 disables lockout.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-low reset; sampled on posedge `clk`.
- `set_req`  in  1  asynchronous set request, active high.
- `clr_req`  in  1  asynchronous clear request, active high.
- `s`  out  1  registered set pulse to the flip-flop, one cycle wide.
- `r`  out  1  registered reset pulse to the flip-flop, one cycle wide.
- `busy`  out  1  high while in lockout.
- `conflict`  out  1  one-cycle pulse when both debounced edges occur on the same cycle.
- `dropped`  out  1  one-cycle pulse when a debounced edge is discarded during lockout.

## Operation
- Per channel: 2-flop synchronizer (`sync1`, `sync2`), debounced level `db`, and counter `cnt` of width $clog2(DB_CYCLES+1).
- Counter rule, evaluated each posedge:
  - If `sync2 == db`, `cnt` ← 0.
  - Otherwise, if `cnt == DB_CYCLES-1`, `db` ← `sync2` and `cnt` ← 0.
  - Otherwise, `cnt` ← `cnt` + 1.
  - Any glitch shorter than `DB_CYCLES` synchronized cycles restarts the count and never changes `db`.
- Edge event: on the posedge where `db` goes 0→1 (`set_ev` or `clr_ev`). Falling edges generate no event.
- FSM states:
  - IDLE:
    - `set_ev` only: `s` ← 1.
    - `clr_ev` only: `r` ← 1.
    - Both events: `r` ← 1 and `conflict` ← 1; clear wins, the safe state.
    - After any command, go to HOLD if `HOLDOFF` > 0; otherwise stay in IDLE.
  - HOLD:
    - Lockout counter `hcnt` runs from `HOLDOFF-1` down to 0; return to IDLE on the posedge where `hcnt == 0`.
    - Any edge event seen in HOLD: no command is issued; `dropped` ← 1.
    - `busy` = 1 throughout HOLD.
- `s`, `r`, `conflict`, and `dropped` default to 0 every cycle unless set as above.
- Invariant: `s & r` is 0 on every cycle.

## Timing
- Reset (`rst` = 0 at posedge):
  - `sync1`, `sync2`, `db`, `cnt`, and `hcnt` clear to 0.
  - FSM enters IDLE.
  - `s`, `r`, `busy`, `conflict`, and `dropped` are 0 from the next cycle.
  - Applies mid-debounce and mid-lockout; any partial count is lost.
- A request line held high through reset release is treated as a new assertion. It produces a command after full debounce, because `db` restarts at 0.
- Latency: request high and stable before posedge k → `sync2` = 1 after k+1 → `db` rises and command pulse is high after posedge k+1+`DB_CYCLES`. With `DB_CYCLES` = 4, `s` is high during the cycle after posedge k+5.
- Command pulse width is exactly 1 cycle regardless of how long the request stays high.
- Lockout: after a command at posedge t, `busy` is high for cycles following posedges t+1 … t+`HOLDOFF`.
  - An event on posedge t+`HOLDOFF` is still dropped.
  - An event on posedge t+`HOLDOFF`+1 is accepted.
  - With `HOLDOFF` = 0, back-to-back events on consecutive cycles are both issued.
- Simultaneous event and lockout expiry: the event is dropped, since the state is still HOLD.

## Test plan
- Reset, then `set_req` = 1 held from posedge 3, defaults → `s` = 1 for exactly one cycle after posedge 8 (3+1+4); `r` stays 0; `busy` high for the next 8 cycles.
- `set_req` pulses high for 3 cycles only (< `DB_CYCLES`) → `s`, `r`, and `dropped` all remain 0; `db` unchanged.
- `set_req` and `clr_req` rise on the same cycle → `r` = 1 and `conflict` = 1 for one cycle; `s` = 0 throughout.
- `set_req` accepted, then `clr_req` rises so its debounced edge lands 4 cycles later (inside lockout) → `dropped` = 1 for one cycle with no `r`. A second clear landing after `busy` falls produces `r` = 1.
- `clr_req` held high; `rst` driven low for 2 cycles mid-debounce (`cnt` = 2), then released → no pulse during reset; `r` = 1 exactly `DB_CYCLES`+2 posedges after release.
- `HOLDOFF` = 0: set edge then clear edge on consecutive cycles → `s` and `r` in consecutive cycles; `busy` never asserts; `s & r` never 1.
